// File: rtl/alu_share_pkg.sv
// Shared types and constants for the ALU share arbiter: op codes, FSM states
// and default operand/result widths.
package alu_share_pkg;

    localparam int DW_DEF = 4;
    localparam int RW_DEF = 5;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_ADD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response/ALU bus between N requesters, the arbiter and the shared ALU.
// slave is the arbiter's view, master the requester/ALU side.
interface alu_share_arbiter_if
    import alu_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
);
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_code;
    logic [DW*N-1:0] req_a;
    logic [DW*N-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [RW-1:0]   rsp_data;
    logic [1:0]      alu_code;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [RW-1:0]   alu_c;
    logic            busy;

    modport slave (
        input  req_valid, req_code, req_a, req_b, rsp_ready, alu_c,
        output req_ready, rsp_valid, rsp_data, alu_code, alu_a, alu_b, busy
    );

    modport master (
        output req_valid, req_code, req_a, req_b, rsp_ready, alu_c,
        input  req_ready, rsp_valid, rsp_data, alu_code, alu_a, alu_b, busy
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward
// with wrap; returns one-hot grant, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any_req
);

    // Scan from farthest to nearest so the position closest to ptr wins last.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_req = |req;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between N requesters.
// Optional per-requester grant counters: define ALU_SHARE_ARBITER_STATS_EN.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
`ifdef ALU_SHARE_ARBITER_STATS_EN
    ,
    output logic [8*N-1:0]      grant_cnt
`endif
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t          state_r, state_nxt;
    logic [IW-1:0]   ptr_r, ptr_nxt;
    logic [IW-1:0]   gidx_r, gidx_nxt;
    logic [N-1:0]    req_ready_r, req_ready_nxt;
    logic [N-1:0]    rsp_valid_r, rsp_valid_nxt;
    logic [RW-1:0]   rsp_data_r, rsp_data_nxt;
    logic [1:0]      alu_code_r, alu_code_nxt;
    logic [DW-1:0]   alu_a_r, alu_a_nxt;
    logic [DW-1:0]   alu_b_r, alu_b_nxt;
    logic            busy_r;

    logic [N-1:0]    grant_s;
    logic [IW-1:0]   gsel_s;
    logic            any_req_s;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req     (bus.req_valid),
        .ptr     (ptr_r),
        .grant   (grant_s),
        .idx     (gsel_s),
        .any_req (any_req_s)
    );

    // Next-state and next-register values; operands only change on a grant.
    always_comb begin
        state_nxt     = state_r;
        ptr_nxt       = ptr_r;
        gidx_nxt      = gidx_r;
        req_ready_nxt = '0;
        rsp_valid_nxt = rsp_valid_r;
        rsp_data_nxt  = rsp_data_r;
        alu_code_nxt  = alu_code_r;
        alu_a_nxt     = alu_a_r;
        alu_b_nxt     = alu_b_r;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    req_ready_nxt = grant_s;
                    alu_code_nxt  = bus.req_code[2*int'(gsel_s) +: 2];
                    alu_a_nxt     = bus.req_a[DW*int'(gsel_s) +: DW];
                    alu_b_nxt     = bus.req_b[DW*int'(gsel_s) +: DW];
                    gidx_nxt      = gsel_s;
                    state_nxt     = EXEC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            EXEC: begin
                rsp_data_nxt          = bus.alu_c;
                rsp_valid_nxt         = '0;
                rsp_valid_nxt[gidx_r] = 1'b1;
                state_nxt             = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[gidx_r]) begin
                    rsp_valid_nxt = '0;
                    ptr_nxt       = (gidx_r == LAST_IDX) ? '0 : gidx_r + ONE_IDX;
                    state_nxt     = IDLE;
                end else begin
                    state_nxt = RESP;
                end
            end
            default: begin
                rsp_valid_nxt = '0;
                state_nxt     = IDLE;
            end
        endcase
    end

    // State and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            gidx_r      <= '0;
            req_ready_r <= '0;
            rsp_valid_r <= '0;
            rsp_data_r  <= '0;
            alu_code_r  <= '0;
            alu_a_r     <= '0;
            alu_b_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            ptr_r       <= ptr_nxt;
            gidx_r      <= gidx_nxt;
            req_ready_r <= req_ready_nxt;
            rsp_valid_r <= rsp_valid_nxt;
            rsp_data_r  <= rsp_data_nxt;
            alu_code_r  <= alu_code_nxt;
            alu_a_r     <= alu_a_nxt;
            alu_b_r     <= alu_b_nxt;
            busy_r      <= (state_nxt != IDLE);
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.alu_code  = alu_code_r;
    assign bus.alu_a     = alu_a_r;
    assign bus.alu_b     = alu_b_r;
    assign bus.busy      = busy_r;

`ifdef ALU_SHARE_ARBITER_STATS_EN
    logic [8*N-1:0] cnt_r;

    // Saturating grant counters, stepped in step with the req_ready pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_ready_nxt[i] && (cnt_r[8*i +: 8] != 8'hFF)) begin
                    cnt_r[8*i +: 8] <= cnt_r[8*i +: 8] + 8'd1;
                end
            end
        end
    end

    assign grant_cnt = cnt_r;
`endif

endmodule
